// File: rtl/serial_pkg.sv
// serial_pkg: framing constants, FSM states and baud divisor shared by the serial TX/RX pair
package serial_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  function automatic int divisor(input int osc_hz, input int baud);
    return osc_hz / baud;
  endfunction
endpackage

// File: rtl/serial_fifo.sv
// serial_fifo: power-of-two circular buffer; a push while full is refused even alongside a pop
module serial_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   osc,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serial_fifo: DEPTH must be a power of 2 and at least 2");
  end
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign w_push = push && !full;
  assign w_pop = pop && !empty;
  assign dout = r_mem[r_rp];
  assign level = r_cnt;
  always_ff @(posedge osc)
    if (w_push) r_mem[r_wp] <= din;
  always_ff @(posedge osc)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter fed by a small FIFO, LSB first, with gapless back-to-back frames
module serial_tx
  import serial_pkg::*;
#(
  parameter int OSCRATE  = 12_000_000,
  parameter int BAUDRATE = 9600,
  parameter int DEPTH    = 4
) (
  input  logic                   osc,
  input  logic                   rst,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int DIVISOR = divisor(OSCRATE, BAUDRATE);
  localparam int CW = $clog2(DIVISOR);
  if (DIVISOR < 2) begin : g_bad_div
    $error("serial_tx: OSCRATE/BAUDRATE must be at least 2");
  end
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic r_tx;
  logic w_full, w_empty, w_bit_end, w_pop;
  logic [7:0] w_head;
  assign w_bit_end = r_cnt == CW'(DIVISOR - 1);
  // Popping at the last stop-bit cycle chains the next start bit with no idle gap
  assign w_pop = !w_empty && (r_state == IDLE ||
                 (r_state == STOP && w_bit_end && r_idx == 3'(STOP_BITS - 1)));
  assign tx_ready = !w_full && !rst;
  assign tx = r_tx;
  assign busy = r_state != IDLE;
  serial_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .osc(osc),
    .rst(rst),
    .push(tx_valid && tx_ready),
    .pop(w_pop),
    .din(tx_data),
    .dout(w_head),
    .full(w_full),
    .empty(w_empty),
    .level(level)
  );
  always_ff @(posedge osc)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_tx <= 1'b1;
    end else begin
      r_cnt <= (r_state == IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
      if (w_pop) begin
        r_state <= START;
        r_shift <= w_head;
        r_idx <= '0;
        r_tx <= 1'b0;
      end else if (w_bit_end) begin
        case (r_state)
          START: begin
            r_state <= DATA;
            r_tx <= r_shift[0];
          end
          DATA: begin
            r_state <= (r_idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
            r_idx <= (r_idx == 3'(DATA_BITS - 1)) ? '0 : r_idx + 1'b1;
            r_tx <= (r_idx == 3'(DATA_BITS - 1)) ? 1'b1 : r_shift[1];
            r_shift <= r_shift >> 1;
          end
          STOP: begin
            r_state <= (r_idx == 3'(STOP_BITS - 1)) ? IDLE : STOP;
            r_idx <= r_idx + 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized self-checking bench for serial_tx at the default and a tiny baud divisor
module tb_serial_tx;
  localparam int DIV_D = 1250;
  localparam int DIV_S = 3;
  logic osc = 1'b0;
  always #5 osc = ~osc;
  logic rst_d = 1'b1, valid_d = 1'b0, ready_d, tx_d, busy_d;
  logic [7:0] data_d = '0;
  logic [2:0] level_d;
  logic rst_s = 1'b1, valid_s = 1'b0, ready_s, tx_s, busy_s;
  logic [7:0] data_s = '0;
  logic [2:0] level_s;
  serial_tx dut_d (
    .osc(osc), .rst(rst_d), .tx_data(data_d), .tx_valid(valid_d),
    .tx_ready(ready_d), .tx(tx_d), .busy(busy_d), .level(level_d)
  );
  serial_tx #(.OSCRATE(10), .BAUDRATE(3), .DEPTH(4)) dut_s (
    .osc(osc), .rst(rst_s), .tx_data(data_s), .tx_valid(valid_s),
    .tx_ready(ready_s), .tx(tx_s), .busy(busy_s), .level(level_s)
  );
  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  always @(posedge osc) cyc <= cyc + 1;
  logic [7:0] got_d[$], got_s[$];
  int unsigned st_d[$], st_s[$];

  // Ideal line level for bit slot k of a frame: start, 8 data LSB first, stop
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    return (k == 0) ? 1'b0 : (k >= 9) ? 1'b1 : b[k-1];
  endfunction

  // Line decoder: finds a start bit, samples mid-bit, and queues the received byte
  task automatic mon(input bit s);
    int div;
    logic [7:0] b;
    logic v;
    bit ab;
    int unsigned t0;
    div = s ? DIV_S : DIV_D;
    forever begin
      @(negedge osc);
      if ((s ? tx_s : tx_d) === 1'b0) begin
        t0 = cyc;
        ab = 0;
        b = '0;
        for (int n = 1; n <= 9 * div + div / 2; n++) begin
          @(negedge osc);
          if ((s ? busy_s : busy_d) !== 1'b1) begin
            ab = 1;
            break;
          end
          if (n % div == div / 2) begin
            v = s ? tx_s : tx_d;
            if (n / div == 0) begin
              tests++;
              if (v !== 1'b0) begin fails++; $display("FAIL mon_start dut%0d: got %b expected 0", s, v); end
            end else if (n / div <= 8) b[n/div-1] = v;
            else begin
              tests++;
              if (v !== 1'b1) begin fails++; $display("FAIL mon_stop dut%0d: got %b expected 1", s, v); end
            end
          end
        end
        if (!ab) begin
          if (s) begin got_s.push_back(b); st_s.push_back(t0); end
          else begin got_d.push_back(b); st_d.push_back(t0); end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_d = 1; rst_s = 1;
    repeat (3) @(negedge osc);
    tests++; if (tx_d !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx_d); end
    tests++; if (busy_d !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_d); end
    tests++; if (level_d !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level_d); end
    tests++; if (ready_d !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready_d); end
    tests++; if ({tx_s, busy_s, ready_s, level_s} !== 6'b100_000) begin
      fails++; $display("FAIL reset_small: got %b expected 100000", {tx_s, busy_s, ready_s, level_s});
    end
    rst_d = 0; rst_s = 0;
    @(negedge osc);
    tests++; if (ready_d !== 1'b1 || tx_d !== 1'b1) begin
      fails++; $display("FAIL reset_release: got ready=%b tx=%b expected 1 1", ready_d, tx_d);
    end
  endtask

  task automatic test_single;
    logic [7:0] b;
    int n;
    b = 8'h55;
    data_d = b; valid_d = 1;
    @(negedge osc);
    valid_d = 0;
    tests++; if (tx_d !== 1'b1 || busy_d !== 1'b0) begin
      fails++; $display("FAIL single_early: got tx=%b busy=%b expected 1 0", tx_d, busy_d);
    end
    tests++; if (level_d !== 3'd1) begin fails++; $display("FAIL single_level: got %0d expected 1", level_d); end
    @(negedge osc);
    tests++; if (tx_d !== 1'b0 || busy_d !== 1'b1) begin
      fails++; $display("FAIL single_start: got tx=%b busy=%b expected 0 1", tx_d, busy_d);
    end
    n = 0;
    while (busy_d === 1'b1 && n < 20000) begin
      if (n % DIV_D == DIV_D / 2 && n < 10 * DIV_D) begin
        tests++;
        if (tx_d !== frame_bit(b, n / DIV_D)) begin
          fails++; $display("FAIL single_bit%0d: got %b expected %b", n / DIV_D, tx_d, frame_bit(b, n / DIV_D));
        end
      end
      n++;
      @(negedge osc);
    end
    tests++; if (n != 10 * DIV_D) begin fails++; $display("FAIL single_busy_len: got %0d expected %0d", n, 10 * DIV_D); end
    tests++; if (got_d.size() != 1 || got_d[0] !== b) begin
      fails++; $display("FAIL single_decode: got %0d bytes first %h expected 1 byte 55", got_d.size(), got_d.size() ? got_d[0] : 8'h0);
    end
    got_d.delete(); st_d.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] bs [2];
    int bad;
    bs[0] = 8'hA5; bs[1] = 8'h3C;
    @(negedge osc);
    data_d = bs[0]; valid_d = 1;
    @(negedge osc);
    data_d = bs[1];
    @(negedge osc);
    valid_d = 0;
    bad = 0;
    for (int n = 0; n < 20 * DIV_D; n++) begin
      if (tx_d !== frame_bit(bs[n/(10*DIV_D)], (n / DIV_D) % 10)) bad++;
      @(negedge osc);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_wave: got %0d wrong cycles expected 0", bad); end
    tests++; if (busy_d !== 1'b0 || tx_d !== 1'b1) begin
      fails++; $display("FAIL b2b_done: got busy=%b tx=%b expected 0 1", busy_d, tx_d);
    end
    tests++; if (st_d.size() != 2 || st_d[1] - st_d[0] != 10 * DIV_D) begin
      fails++; $display("FAIL b2b_spacing: got %0d starts gap %0d expected 2 starts gap %0d",
                        st_d.size(), st_d.size() == 2 ? st_d[1] - st_d[0] : 0, 10 * DIV_D);
    end
    tests++; if (got_d.size() != 2 || got_d[0] !== bs[0] || got_d[1] !== bs[1]) begin
      fails++; $display("FAIL b2b_decode: got %0d bytes expected a5 3c", got_d.size());
    end
    got_d.delete(); st_d.delete();
  endtask

  task automatic test_burst;
    logic [7:0] exp[$];
    int acc, n;
    bit took;
    acc = 0;
    @(negedge osc);
    data_d = 8'($urandom); valid_d = 1;
    for (int i = 0; i < 20; i++) begin
      took = ready_d;
      if (took) begin exp.push_back(data_d); acc++; end
      @(negedge osc);
      if (took) data_d = 8'($urandom);
    end
    tests++; if (acc != 5) begin fails++; $display("FAIL burst_accepted: got %0d expected 5", acc); end
    tests++; if (ready_d !== 1'b0) begin fails++; $display("FAIL burst_ready_low: got %b expected 0", ready_d); end
    tests++; if (level_d !== 3'd4) begin fails++; $display("FAIL burst_level: got %0d expected 4", level_d); end
    n = 0;
    while (ready_d !== 1'b1 && n < 15000) begin @(negedge osc); n++; end
    valid_d = 0;
    tests++; if (st_d.size() < 1 || cyc - st_d[0] != 10 * DIV_D) begin
      fails++; $display("FAIL burst_ready_back: got %0d cycles after first start expected %0d",
                        st_d.size() ? cyc - st_d[0] : 0, 10 * DIV_D);
    end
    tests++; if (level_d !== 3'd3) begin fails++; $display("FAIL burst_level_after_pop: got %0d expected 3", level_d); end
    tests++; if (got_d.size() < 1 || got_d[0] !== exp[0]) begin
      fails++; $display("FAIL burst_first_byte: got %h expected %h", got_d.size() ? got_d[0] : 8'h0, exp[0]);
    end
    rst_d = 1;
    @(negedge osc);
    rst_d = 0;
    repeat (2) @(negedge osc);
    got_d.delete(); st_d.delete();
  endtask

  task automatic test_reset_mid;
    int bad;
    for (int i = 0; i < 3; i++) begin
      @(negedge osc);
      data_d = 8'($urandom); valid_d = 1;
    end
    @(negedge osc);
    valid_d = 0;
    repeat (4 * DIV_D + DIV_D / 2 - 1) @(negedge osc);
    tests++; if (level_d !== 3'd2 || busy_d !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got level=%0d busy=%b expected 2 1", level_d, busy_d);
    end
    rst_d = 1;
    @(negedge osc);
    rst_d = 0;
    tests++; if (tx_d !== 1'b1 || busy_d !== 1'b0 || level_d !== 3'd0) begin
      fails++; $display("FAIL rstmid_after: got tx=%b busy=%b level=%0d expected 1 0 0", tx_d, busy_d, level_d);
    end
    bad = 0;
    for (int n = 0; n < 2 * DIV_D; n++) begin
      @(negedge osc);
      if (tx_d !== 1'b1 || busy_d !== 1'b0) bad++;
    end
    tests++; if (bad != 0 || got_d.size() != 0) begin
      fails++; $display("FAIL rstmid_quiet: got %0d active cycles %0d frames expected 0 0", bad, got_d.size());
    end
  endtask

  task automatic test_small_frame;
    logic [7:0] b;
    int bad_tx, bad_busy;
    b = 8'($urandom);
    @(negedge osc);
    data_s = b; valid_s = 1;
    @(negedge osc);
    valid_s = 0;
    @(negedge osc);
    bad_tx = 0; bad_busy = 0;
    for (int n = 0; n < 36; n++) begin
      if (tx_s !== (n < 30 ? frame_bit(b, n / DIV_S) : 1'b1)) bad_tx++;
      if (busy_s !== (n < 30)) bad_busy++;
      @(negedge osc);
    end
    tests++; if (bad_tx != 0) begin fails++; $display("FAIL small_wave: got %0d wrong cycles expected 0", bad_tx); end
    tests++; if (bad_busy != 0) begin fails++; $display("FAIL small_busy: got %0d wrong cycles expected 0", bad_busy); end
    tests++; if (got_s.size() != 1 || got_s[0] !== b) begin
      fails++; $display("FAIL small_decode: got %0d bytes expected 1 byte %h", got_s.size(), b);
    end
    got_s.delete(); st_s.delete();
  endtask

  task automatic test_wrap;
    int i, g;
    i = 0; g = 0;
    @(negedge osc);
    while (i < 10 && g < 2000) begin
      data_s = 8'(i); valid_s = 1;
      if (ready_s) i++;
      @(negedge osc);
      g++;
    end
    valid_s = 0;
    g = 0;
    while ((busy_s !== 1'b0 || level_s !== 3'd0) && g < 2000) begin @(negedge osc); g++; end
    tests++; if (got_s.size() != 10) begin fails++; $display("FAIL wrap_count: got %0d expected 10", got_s.size()); end
    for (int k = 0; k < got_s.size() && k < 10; k++) begin
      tests++;
      if (got_s[k] !== 8'(k)) begin fails++; $display("FAIL wrap_byte%0d: got %h expected %h", k, got_s[k], 8'(k)); end
    end
    got_s.delete(); st_s.delete();
  endtask

  task automatic test_random;
    logic [7:0] exp[$];
    int sent, g, bad;
    sent = 0; g = 0;
    while (sent < 40 && g < 5000) begin
      @(negedge osc);
      valid_s = 1'($urandom_range(0, 1));
      data_s = 8'($urandom);
      if (valid_s && ready_s) begin exp.push_back(data_s); sent++; end
      g++;
    end
    @(negedge osc);
    valid_s = 0;
    g = 0;
    while ((busy_s !== 1'b0 || level_s !== 3'd0) && g < 3000) begin @(negedge osc); g++; end
    tests++; if (g >= 3000) begin fails++; $display("FAIL rand_drain: got busy=%b level=%0d expected idle", busy_s, level_s); end
    tests++; if (got_s.size() != exp.size()) begin
      fails++; $display("FAIL rand_count: got %0d expected %0d", got_s.size(), exp.size());
    end
    bad = 0;
    for (int k = 0; k < exp.size() && k < got_s.size(); k++) if (got_s[k] !== exp[k]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL rand_bytes: got %0d wrong bytes expected 0", bad); end
    got_s.delete(); st_s.delete();
  endtask

  initial begin
    fork
      mon(1'b0);
      mon(1'b1);
    join_none
    test_reset;
    test_single;
    test_back_to_back;
    test_burst;
    test_reset_mid;
    test_small_frame;
    test_wrap;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
# serial_tx

UART transmitter for the chiptune ASIC: the return direction of the 9600-baud serial command link. It accepts bytes over a valid/ready handshake into a small FIFO and shifts them out on a single pin as 8N1 frames, LSB first. It sits beside the serial receiver inside the chiptune core and drives the COM port TX line, for example to echo commands or report status.

## Interface
- OSCRATE, 12_000_000: oscillator frequency in Hz.
- BAUDRATE, 9600: serial bit rate.
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.
- osc  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept a byte.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress.
- level  out  $clog2(DEPTH)+1  number of bytes held in the FIFO.

## Operation
- Bit period: DIVISOR = OSCRATE/BAUDRATE, using integer truncation. The default is 1250 cycles. DIVISOR must be at least 2; enforce this with an elaboration-time check.
- Handshake:
  - A byte is accepted on any rising edge where tx_valid && tx_ready.
  - tx_ready = !full && !rst. This is combinational from the FIFO count.
  - There is no pass-through: a push while full is refused, even if a pop occurs in the same cycle.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - A push and a pop in the same cycle leave level unchanged.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: if level != 0, pop the head into the shift register, clear the baud counter and bit index, and go to START. Otherwise stay in IDLE with tx=1.
  - START: tx=0 for DIVISOR cycles, then go to DATA.
  - DATA: tx = shift[0] for DIVISOR cycles per bit, then shift right. Advance the bit index 0..7 and go to STOP after bit 7.
  - STOP: tx=1 for DIVISOR cycles. At the end of the stop bit:
    - if level != 0, pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- Baud counter: counts 0..DIVISOR-1. It wraps to 0 at the end of each bit and is cleared at the start of each frame.
- tx is driven from a flop, so the output is glitch-free.
- busy = (state != IDLE).
- Reset values while rst is high and on the first edge after it:
  - tx=1, busy=0, level=0, tx_ready=0 during rst.
  - State is IDLE; pointers and counters are 0.
  - FIFO contents are don't-care.
- Reset mid-frame aborts the frame. tx is high after the reset edge, and all queued bytes are discarded.

## Timing
- Latency from idle: a byte accepted on edge E (FIFO empty, state IDLE) is popped on edge E+1. tx falls low after edge E+1 and busy rises after the same edge.
- Each start, data and stop bit lasts exactly DIVISOR cycles, so one frame is 10×DIVISOR cycles (12500 at the defaults).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- level reflects a push or pop on the edge after it occurs.
- tx_ready returns high in the cycle after the pop that frees a slot.

## Structure
- Shared package serial_pkg:
  - state enum (IDLE, START, DATA, STOP);
  - DIVISOR computation function;
  - frame constants: DATA_BITS=8, STOP_BITS=1.
- The receiver uses the same package, so both directions agree on framing.
- Sub-module serial_fifo: parameterized on DEPTH and WIDTH=8, with ports push/pop/full/empty/level. serial_tx instantiates it and contains the state machine and baud counter.

## Test plan
- Single byte 0x55 at the default parameters:
  - sample tx at the middle of each 1250-cycle bit and require 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop);
  - tx falls low after the edge following the accepting edge;
  - busy is high for exactly 12500 cycles.
- Back-to-back bytes 0xA5 then 0x3C pushed on consecutive cycles:
  - second start edge exactly 12500 cycles after the first;
  - tx never goes high between the frames except in the stop bit;
  - decoded bits match both bytes.
- Burst with DEPTH=4 and tx_valid held high from idle:
  - exactly 5 bytes accepted (one popped immediately), then tx_ready=0 and level=4;
  - tx_ready reasserts one cycle after the pop at the end of the first frame.
- FIFO wrap: with DEPTH=4, stream 10 bytes 0x00..0x09 honoring tx_ready -> all 10 frames decoded in order, no loss or duplication.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 with level=2 -> tx=1, busy=0 and level=0 on the next edge, and no further frames are sent.
- Small parameters OSCRATE=10, BAUDRATE=3 (DIVISOR=3 by truncation) -> every bit lasts exactly 3 cycles and a frame takes 30 cycles.
